multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the RV32I datapath (PC, register unit, ALU, data memory) behind a shared single-port memory with a ready handshake.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and emits the write enables (PC, IR, register file, data memory) plus memory request strobes.
- Sits beside the existing decode control unit, which still supplies ALU/mux selects.
- This block only decides when things happen.

Parameters:
- MEM_TIMEOUT, 16: consecutive MemReady-low cycles while MemReq is high before FAULT; 0 disables the timeout.
- CNT_W, 32: width of the performance counters (used only with SEQ_PERF_CNT_EN).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- Run  in  1  start request; sampled only in IDLE.
- Op  in  7  opcode field from the instruction register; sampled only in DECODE.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request.
- MemData  out  1  1 = data access, 0 = instruction fetch.
- IRWr  out  1  load instruction register.
- PCWr  out  1  load PC with next-PC mux output.
- RUWrEn  out  1  register-file write enable (gates control-unit RUWr).
- DMWrEn  out  1  data-memory write strobe.
- Busy  out  1  in FETCH, DECODE, EXEC, MEM or WB.
- Halted  out  1  in HALT.
- Fault  out  1  in FAULT.
- State  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.

Behaviour:
- Reset:
  - RST high at an edge gives State=IDLE, wait counter=0, latched class=NONE and perf counters=0.
  - While RST is high, all strobes (MemReq, IRWr, PCWr, RUWrEn, DMWrEn) are forced 0 combinationally, including mid-access.
- Output timing: Busy, Halted, Fault, State, MemReq, MemData and RUWrEn are decoded from State. IRWr, DMWrEn and PCWr-in-MEM also depend on MemReady in the same cycle.
- IDLE: Run=1 goes to FETCH next cycle; otherwise stay.
- FETCH: MemReq=1, MemData=0. If MemReady=1: IRWr=1 this cycle, go to DECODE.
- DECODE (1 cycle): classify Op and latch the class. Later Op changes are ignored until the next DECODE.
  - 0110011 / 0010011 / 0110111 / 0010111 / 1101111 / 1100111 -> ALU class.
  - 0000011 -> LOAD.
  - 0100011 -> STORE.
  - 1100011 -> BRANCH.
  - 1110011 -> go to HALT.
  - Any other value -> go to FAULT.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - BRANCH: PCWr=1, go to FETCH.
  - LOAD or STORE: go to MEM.
  - ALU: go to WB.
- MEM: MemReq=1, MemData=1. On MemReady=1:
  - STORE: DMWrEn=1 and PCWr=1 this cycle, go to FETCH.
  - LOAD: go to WB.
  - DMWrEn is never asserted without MemReady.
- WB (1 cycle): RUWrEn=1, PCWr=1, go to FETCH.
- HALT and FAULT: terminal until RST. Run is ignored. All strobes are 0.
- Timeout (FETCH and MEM only):
  - Wait counter clears on state entry and on MemReady=1; it increments on each cycle with MemReq=1 and MemReady=0.
  - When MEM_TIMEOUT≠0 and MemReady has been low for MEM_TIMEOUT consecutive cycles, go to FAULT at that edge. MemReady arriving in cycle MEM_TIMEOUT of the wait is still accepted.
  - Counter saturates; it never wraps.
- Instruction retirement: the cycle PCWr=1 retires an instruction.
- Latency with MemReady tied high:
  - ALU: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Run is ignored outside IDLE. MemReady is ignored outside FETCH and MEM.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: adds two ports, both 0 after reset and wrapping modulo 2^CNT_W:
  - CycleCnt (out, CNT_W): increments every cycle Busy=1.
  - InstRet (out, CNT_W): increments every cycle PCWr=1.
- Not defined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- ALU op: RST, Run=1 pulse, Op=0110011, MemReady=1 → State sequence 1,2,3,5,1. IRWr high only in the FETCH cycle; RUWrEn and PCWr high only in the WB cycle.
- LOAD then STORE: Op=0000011 then 0100011, MemReady=1 → states 1,2,3,4,5 then 1,2,3,4. DMWrEn exactly one cycle (store MEM). RUWrEn only in the load WB.
- Wait states: BRANCH (1100011) with MemReady low for 3 FETCH cycles, then high → IRWr only in the 4th FETCH cycle. Then DECODE, EXEC with PCWr=1, back to FETCH.
- Timeout, MEM_TIMEOUT=4:
  - MemReady held 0 in FETCH → FAULT after 4 FETCH cycles; Fault=1, State=7, all strobes 0. Run=1 has no effect.
  - Repeat with MemReady=1 in the 4th cycle → DECODE, no fault.
- Illegal Op=0000000 → FAULT right after DECODE. Op=1110011 → HALT, Halted=1; stays in HALT until RST.
- RST asserted in MEM of a store while MemReady=1 → DMWrEn=0 that cycle, State=0 next cycle. With SEQ_PERF_CNT_EN: CycleCnt=0 and InstRet=0, and after one ALU instruction InstRet=1 and CycleCnt=4.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for an RV32I datapath on a shared memory.
// Optional performance counters (CycleCnt, InstRet) are built when SEQ_PERF_CNT_EN is defined.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Run,
    input  logic [6:0]       Op,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemData,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RUWrEn,
    output logic             DMWrEn,
    output logic             Busy,
    output logic             Halted,
    output logic             Fault,
    output logic [2:0]       State
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstRet
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_ALU,
        C_LOAD,
        C_STORE,
        C_BRANCH
    } iclass_t;

    // Counter only has to reach MEM_TIMEOUT-1; a zero timeout still gets a 1-bit counter.
    localparam int                WAIT_LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT : 1;
    localparam int                WAIT_W     = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_LIMIT - 1);

    state_t            state, state_next;
    iclass_t           iclass, iclass_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;

    logic mem_req_raw;
    logic ir_wr_raw;
    logic pc_wr_raw;
    logic ru_wr_raw;
    logic dm_wr_raw;

    assign timed_out = (MEM_TIMEOUT != 0) && !MemReady && (wait_cnt == WAIT_LAST);

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next  = state;
        iclass_next = iclass;
        mem_req_raw = 1'b0;
        MemData     = 1'b0;
        ir_wr_raw   = 1'b0;
        pc_wr_raw   = 1'b0;
        ru_wr_raw   = 1'b0;
        dm_wr_raw   = 1'b0;

        case (state)
            S_IDLE: begin
                if (Run) state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req_raw = 1'b1;
                if (MemReady) begin
                    ir_wr_raw  = 1'b1;
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                state_next  = S_EXEC;
                iclass_next = C_NONE;
                case (Op)
                    7'b0110011, 7'b0010011, 7'b0110111,
                    7'b0010111, 7'b1101111, 7'b1100111: iclass_next = C_ALU;
                    7'b0000011:                         iclass_next = C_LOAD;
                    7'b0100011:                         iclass_next = C_STORE;
                    7'b1100011:                         iclass_next = C_BRANCH;
                    7'b1110011:                         state_next  = S_HALT;
                    default:                            state_next  = S_FAULT;
                endcase
            end
            S_EXEC: begin
                case (iclass)
                    C_BRANCH: begin
                        pc_wr_raw  = 1'b1;
                        state_next = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_next = S_MEM;
                    C_ALU:           state_next = S_WB;
                    default:         state_next = S_FAULT;
                endcase
            end
            S_MEM: begin
                mem_req_raw = 1'b1;
                MemData     = 1'b1;
                if (MemReady) begin
                    if (iclass == C_STORE) begin
                        dm_wr_raw  = 1'b1;
                        pc_wr_raw  = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timed_out) begin
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                ru_wr_raw  = 1'b1;
                pc_wr_raw  = 1'b1;
                state_next = S_FETCH;
            end
            default: ;  // HALT and FAULT hold until reset
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            iclass   <= C_NONE;
            wait_cnt <= '0;
        end else begin
            state  <= state_next;
            iclass <= iclass_next;
            if (state_next != state || (mem_req_raw && MemReady))
                wait_cnt <= '0;
            else if (mem_req_raw && wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Reset overrides strobes combinationally so an in-flight access is dropped immediately.
    assign MemReq = mem_req_raw & ~RST;
    assign IRWr   = ir_wr_raw   & ~RST;
    assign PCWr   = pc_wr_raw   & ~RST;
    assign RUWrEn = ru_wr_raw   & ~RST;
    assign DMWrEn = dm_wr_raw   & ~RST;

    assign State  = state;
    assign Busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                    (state == S_MEM)   || (state == S_WB);
    assign Halted = (state == S_HALT);
    assign Fault  = (state == S_FAULT);

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            CycleCnt <= '0;
            InstRet  <= '0;
        end else begin
            if (Busy) CycleCnt <= CycleCnt + 1'b1;
            if (PCWr) InstRet  <= InstRet + 1'b1;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: expected per-cycle outputs go into a scoreboard queue
// that an independent monitor drains on the falling edge.
module tb_multicycle_sequencer;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [6:0] OP_BAD = 7'b0000000;

    typedef struct packed {
        logic [2:0] st;
        logic       req, data, ir, pc, ru, dm, busy, halted, fault;
    } obs_t;

    typedef struct {
        int   idx;
        obs_t v;
    } sb_entry_t;

    logic       CLK = 1'b0;
    logic       RST, Run, MemReady;
    logic [6:0] Op;
    logic       MemReq, MemData, IRWr, PCWr, RUWrEn, DMWrEn, Busy, Halted, Fault;
    logic [2:0] State;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] CycleCnt, InstRet;
`endif

    int total = 0;
    int bad   = 0;
    int step_idx = 0;
    sb_entry_t sb_q[$];

    always #5 CLK = ~CLK;

    multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .Run(Run), .Op(Op), .MemReady(MemReady),
        .MemReq(MemReq), .MemData(MemData), .IRWr(IRWr), .PCWr(PCWr),
        .RUWrEn(RUWrEn), .DMWrEn(DMWrEn), .Busy(Busy), .Halted(Halted),
        .Fault(Fault), .State(State)
`ifdef SEQ_PERF_CNT_EN
        , .CycleCnt(CycleCnt), .InstRet(InstRet)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge and queue the expected outputs for that cycle.
    task automatic step(input bit rst, input bit run, input logic [6:0] op, input bit rdy,
                        input int st, input bit ir, input bit pc, input bit ru, input bit dm);
        sb_entry_t e;
        @(posedge CLK);
        #1;
        RST = rst; Run = run; Op = op; MemReady = rdy;
        step_idx++;
        e.idx      = step_idx;
        e.v.st     = 3'(st);
        e.v.req    = ((st == 1) || (st == 4)) && !rst;
        e.v.data   = (st == 4);
        e.v.ir     = ir;
        e.v.pc     = pc;
        e.v.ru     = ru;
        e.v.dm     = dm;
        e.v.busy   = (st >= 1) && (st <= 5);
        e.v.halted = (st == 6);
        e.v.fault  = (st == 7);
        sb_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            obs_t      act;
            e   = sb_q.pop_front();
            act = '{State, MemReq, MemData, IRWr, PCWr, RUWrEn, DMWrEn, Busy, Halted, Fault};
            check($sformatf("cycle%0d {st,req,data,ir,pc,ru,dm,busy,halt,fault}", e.idx),
                  32'(act), 32'(e.v));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; Run = 1'b0; Op = OP_BAD; MemReady = 1'b0;
        repeat (2) @(posedge CLK);

        // Reset state, then ALU instruction: 1,2,3,5; Op change after DECODE is ignored
        step(1, 0, OP_BAD, 1, 0, 0, 0, 0, 0);
        step(0, 1, OP_ALU, 1, 0, 0, 0, 0, 0);
        step(0, 0, OP_ALU, 1, 1, 1, 0, 0, 0);
        step(0, 0, OP_ALU, 1, 2, 0, 0, 0, 0);
        step(0, 0, OP_BAD, 1, 3, 0, 0, 0, 0);
        step(0, 0, OP_BAD, 1, 5, 0, 1, 1, 0);

        // LOAD: 1,2,3,4,5
        step(0, 0, OP_LD,  1, 1, 1, 0, 0, 0);
        step(0, 0, OP_LD,  1, 2, 0, 0, 0, 0);
        step(0, 0, OP_ST,  1, 3, 0, 0, 0, 0);
        step(0, 0, OP_ST,  1, 4, 0, 0, 0, 0);
        step(0, 0, OP_ST,  1, 5, 0, 1, 1, 0);

        // STORE: 1,2,3,4 with DMWrEn and PCWr in MEM
        step(0, 0, OP_ST,  1, 1, 1, 0, 0, 0);
        step(0, 0, OP_ST,  1, 2, 0, 0, 0, 0);
        step(0, 0, OP_LD,  1, 3, 0, 0, 0, 0);
        step(0, 0, OP_BR,  1, 4, 0, 1, 0, 1);

        // BRANCH with three FETCH wait states
        step(0, 0, OP_BR,  0, 1, 0, 0, 0, 0);
        step(0, 0, OP_BR,  0, 1, 0, 0, 0, 0);
        step(0, 0, OP_BR,  0, 1, 0, 0, 0, 0);
        step(0, 0, OP_BR,  1, 1, 1, 0, 0, 0);
        step(0, 0, OP_BR,  1, 2, 0, 0, 0, 0);
        step(0, 0, OP_BR,  0, 3, 0, 1, 0, 0);

        // FETCH timeout after 4 stalled cycles; FAULT ignores Run
        repeat (4) step(0, 0, OP_BR, 0, 1, 0, 0, 0, 0);
        step(0, 1, OP_BR,  1, 7, 0, 0, 0, 0);
        step(0, 1, OP_BR,  1, 7, 0, 0, 0, 0);
        step(1, 0, OP_BR,  1, 7, 0, 0, 0, 0);

        // MemReady in the 4th wait cycle is accepted; then illegal opcode faults
        step(0, 1, OP_BR,  0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, OP_BAD, 0, 1, 0, 0, 0, 0);
        step(0, 0, OP_BAD, 1, 1, 1, 0, 0, 0);
        step(0, 0, OP_BAD, 1, 2, 0, 0, 0, 0);
        step(0, 0, OP_BAD, 1, 7, 0, 0, 0, 0);
        step(1, 0, OP_BAD, 1, 7, 0, 0, 0, 0);

        // SYSTEM opcode halts and stays halted
        step(0, 1, OP_SYS, 1, 0, 0, 0, 0, 0);
        step(0, 0, OP_SYS, 1, 1, 1, 0, 0, 0);
        step(0, 0, OP_SYS, 1, 2, 0, 0, 0, 0);
        step(0, 1, OP_SYS, 1, 6, 0, 0, 0, 0);
        step(0, 1, OP_SYS, 1, 6, 0, 0, 0, 0);
        step(1, 0, OP_ST,  1, 6, 0, 0, 0, 0);

        // Reset during store MEM with MemReady high: no write strobe
        step(0, 1, OP_ST,  1, 0, 0, 0, 0, 0);
        step(0, 0, OP_ST,  1, 1, 1, 0, 0, 0);
        step(0, 0, OP_ST,  1, 2, 0, 0, 0, 0);
        step(0, 0, OP_ST,  1, 3, 0, 0, 0, 0);
        step(1, 0, OP_ST,  1, 4, 0, 0, 0, 0);
        step(0, 0, OP_ALU, 1, 0, 0, 0, 0, 0);
`ifdef SEQ_PERF_CNT_EN
        check("cyclecnt_after_reset", CycleCnt, 32'd0);
        check("instret_after_reset",  InstRet,  32'd0);
`endif

        // One ALU instruction for the performance counters
        step(0, 1, OP_ALU, 1, 0, 0, 0, 0, 0);
        step(0, 0, OP_ALU, 1, 1, 1, 0, 0, 0);
        step(0, 0, OP_ALU, 1, 2, 0, 0, 0, 0);
        step(0, 0, OP_ALU, 1, 3, 0, 0, 0, 0);
        step(0, 0, OP_ALU, 1, 5, 0, 1, 1, 0);
        step(0, 0, OP_ALU, 0, 1, 0, 0, 0, 0);
`ifdef SEQ_PERF_CNT_EN
        check("cyclecnt_after_alu", CycleCnt, 32'd4);
        check("instret_after_alu",  InstRet,  32'd1);
`endif

        @(negedge CLK);
        @(negedge CLK);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
